// File: rtl/ps2_device.sv
// PS/2 device-side link controller.
// Sends bytes (scan codes) to a host and receives host-to-device command frames.
// Frames are start(0), 8 data bits LSB first, odd parity, stop(1); the device always
// generates the PS/2 clock.
//
// Ports:
//   clk, n_rst            system clock, asynchronous active-low reset
//   clk_in, data_in       sensed PS/2 clock/data lines (asynchronous, synchronized here)
//   n_clk_out, n_data_out open-drain pulls: 0 drives the line low, 1 releases it
//   tx_data/tx_valid/tx_ready  byte to send, valid/ready handshake
//   rx_data/rx_valid/rx_parity_err  received byte, 1-cycle strobe, frame error flag
//   busy                  a frame is in progress in either direction
module ps2_device #(
    parameter int unsigned HALF_BIT    = 20,
    parameter int unsigned INHIBIT_MIN = 50
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clk_in,
    input  logic       data_in,
    output logic       n_clk_out,
    output logic       n_data_out,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       busy
);

    localparam logic [8:0]  HalfBit = 9'(HALF_BIT);
    localparam logic [8:0]  HalfM1  = 9'(HALF_BIT - 1);
    localparam logic [8:0]  FullM1  = 9'(2 * HALF_BIT - 1);
    localparam logic [8:0]  HiNeed  = 9'(2 * HALF_BIT);
    localparam logic [15:0] LowNeed = 16'(INHIBIT_MIN);

    typedef enum logic [2:0] {
        StIdle, StTxHi, StTxLo, StTxHold, StRxWait, StRxHi, StRxLo, StRxAck
    } state_e;

    state_e      state_q, state_d;
    logic        clk_s1_q, clk_s1_d, clk_s_q, clk_s_d;
    logic        dat_s1_q, dat_s1_d, dat_s_q, dat_s_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [15:0] low_cnt_q, low_cnt_d;
    logic [8:0]  hi_cnt_q, hi_cnt_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic [9:0]  rx_sr_q, rx_sr_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_perr_q, rx_perr_d;
    logic        n_clk_out_q, n_clk_out_d;
    logic        n_data_out_q, n_data_out_d;
    logic        tx_ready_q, tx_ready_d;
    logic        busy_q, busy_d;
    logic [10:0] tx_frame;
    logic        half_done;

    always_comb begin
        tx_frame  = {1'b1, ~^pend_data_q, pend_data_q, 1'b0};
        half_done = (cnt_q == HalfM1);

        state_d     = state_q;
        clk_s1_d    = clk_in;
        clk_s_d     = clk_s1_q;
        dat_s1_d    = data_in;
        dat_s_d     = dat_s1_q;
        cnt_d       = cnt_q + 9'd1;
        bit_idx_d   = bit_idx_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        rx_sr_d     = rx_sr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_perr_d   = rx_perr_q;

        // Consecutive host-held low time; our own clock pulses never count as inhibit.
        if (!clk_s_q && n_clk_out_q) begin
            low_cnt_d = (low_cnt_q >= LowNeed) ? low_cnt_q : low_cnt_q + 16'd1;
        end else begin
            low_cnt_d = '0;
        end
        if (clk_s_q) begin
            hi_cnt_d = (hi_cnt_q >= HiNeed) ? hi_cnt_q : hi_cnt_q + 9'd1;
        end else begin
            hi_cnt_d = '0;
        end

        if (tx_valid && tx_ready_q) begin
            pend_d      = 1'b1;
            pend_data_d = tx_data;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Request-to-send wins over a pending transmit byte.
                if (clk_s_q && !dat_s_q && (low_cnt_q >= LowNeed)) begin
                    state_d = StRxWait;
                end else if (pend_q && (hi_cnt_q >= HiNeed)) begin
                    state_d   = StTxHi;
                    bit_idx_d = 4'd0;
                end
            end
            StTxHi: if (half_done) begin
                cnt_d   = '0;
                state_d = clk_s_q ? StTxLo : StIdle;  // host inhibit aborts, byte kept
            end
            StTxLo: if (half_done) begin
                cnt_d = '0;
                if (bit_idx_q == 4'd10) begin
                    state_d = StTxHold;
                end else begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    state_d   = StTxHi;
                end
            end
            StTxHold: if (half_done) begin
                pend_d  = 1'b0;
                state_d = StIdle;
            end
            StRxWait: if (half_done) begin
                cnt_d     = '0;
                bit_idx_d = 4'd0;
                state_d   = StRxLo;
            end
            StRxLo: if (half_done) begin
                cnt_d = '0;
                // Shift in from the top: after 11 samples the start bit has fallen off.
                rx_sr_d = {dat_s_q, rx_sr_q[9:1]};
                state_d = (bit_idx_q == 4'd10) ? StRxAck : StRxHi;
            end
            StRxHi: if (half_done) begin
                cnt_d = '0;
                if (!clk_s_q) begin
                    state_d = StIdle;
                end else begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    state_d   = StRxLo;
                end
            end
            StRxAck: if (cnt_q == FullM1) begin
                rx_data_d  = rx_sr_q[7:0];
                rx_perr_d  = (^rx_sr_q[8:0] == 1'b0) || !rx_sr_q[9];
                rx_valid_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered and follow the next state.
        n_clk_out_d = !((state_d == StTxLo) || (state_d == StRxLo) ||
                        ((state_d == StRxAck) && (cnt_d >= HalfBit)));
        if ((state_d == StTxHi) || (state_d == StTxLo)) begin
            n_data_out_d = tx_frame[bit_idx_d];
        end else begin
            n_data_out_d = (state_d != StRxAck);
        end
        busy_d     = (state_d != StIdle);
        tx_ready_d = (state_d == StIdle) && !pend_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StIdle;
            clk_s1_q     <= 1'b1;
            clk_s_q      <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s_q      <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            low_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            rx_sr_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_perr_q    <= 1'b0;
            n_clk_out_q  <= 1'b1;
            n_data_out_q <= 1'b1;
            tx_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_s1_q     <= clk_s1_d;
            clk_s_q      <= clk_s_d;
            dat_s1_q     <= dat_s1_d;
            dat_s_q      <= dat_s_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            low_cnt_q    <= low_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            rx_sr_q      <= rx_sr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_perr_q    <= rx_perr_d;
            n_clk_out_q  <= n_clk_out_d;
            n_data_out_q <= n_data_out_d;
            tx_ready_q   <= tx_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign n_clk_out     = n_clk_out_q;
    assign n_data_out    = n_data_out_q;
    assign tx_ready      = tx_ready_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_ps2_device.sv
// Bench for ps2_device: models a PS/2 host on wired-AND lines, scoreboards transmitted
// frame bits and received bytes against queues filled when stimulus is applied.
module tb_ps2_device;

    localparam int unsigned HALF_BIT    = 8;
    localparam int unsigned INHIBIT_MIN = 30;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       host_clk, host_data;
    logic       clk_in, data_in;
    logic       n_clk_out, n_data_out;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_parity_err, busy;

    assign clk_in  = host_clk & n_clk_out;
    assign data_in = host_data & n_data_out;

    ps2_device #(.HALF_BIT(HALF_BIT), .INHIBIT_MIN(INHIBIT_MIN)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .clk_in        (clk_in),
        .data_in       (data_in),
        .n_clk_out     (n_clk_out),
        .n_data_out    (n_data_out),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       perr;
    } rx_exp_t;

    logic    tx_exp_q[$];
    rx_exp_t rx_exp_q[$];
    int      n_vec = 0;
    int      n_err = 0;
    int      rx_cnt = 0;
    logic    rxv_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Odd parity: parity bit = ~^data.
    function automatic logic [10:0] make_frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    // sel: 0 = n_clk_out, 1 = n_data_out, 2 = tx_ready
    task automatic wait_for(input int sel, input logic lvl, input string tag);
        logic ok;
        logic v;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            case (sel)
                0:       v = n_clk_out;
                1:       v = n_data_out;
                default: v = tx_ready;
            endcase
            if (v == lvl) begin
                ok = 1'b1;
                break;
            end
        end
        check_val(tag, 32'(ok), 32'(1));
    endtask

    task automatic send_tx(input logic [7:0] b);
        logic [10:0] fr;
        wait_for(2, 1'b1, "tx_ready_wait");
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        fr = make_frame(b);
        for (int i = 0; i < 11; i++) tx_exp_q.push_back(fr[i]);
        check_val("tx_ready_after_accept", 32'(tx_ready), 32'(0));
    endtask

    task automatic capture_tx(input int n, input bit first_seen);
        logic exp_b;
        int   w;
        for (int i = 0; i < n; i++) begin
            if (!(first_seen && (i == 0))) wait_for(0, 1'b0, "tx_clk_fall");
            if (i == 0) check_val("tx_busy", 32'(busy), 32'(1));
            exp_b = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 1'bx;
            check_val($sformatf("tx_bit%0d", i), 32'(n_data_out), 32'(exp_b));
            w = 1;
            for (int k = 0; k < 600; k++) begin
                @(posedge clk);
                #1;
                if (n_clk_out) break;
                w++;
            end
            check_val("tx_low_width", w, HALF_BIT);
        end
    endtask

    task automatic finish_tx();
        check_val("tx_hold_ready", 32'(tx_ready), 32'(0));
        check_val("tx_hold_data", 32'(n_data_out), 32'(1));
        wait_for(2, 1'b1, "tx_ready_back");
        check_val("tx_idle_busy", 32'(busy), 32'(0));
    endtask

    task automatic host_rts();
        host_clk = 1'b0;
        repeat (INHIBIT_MIN + 10) @(posedge clk);
        #1;
        host_data = 1'b0;
        @(posedge clk);
        #1;
        host_clk = 1'b1;
    endtask

    // Let the device clock bits 0..last; the host changes data after each rising edge.
    task automatic host_bits(input logic [10:0] fr, input int last);
        for (int i = 0; i <= last; i++) begin
            wait_for(0, 1'b0, "rx_clk_low");
            if (i < last) begin
                wait_for(0, 1'b1, "rx_clk_high");
                host_data = fr[i + 1];
            end
        end
    endtask

    task automatic host_send(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] fr;
        rx_exp_t     e;
        int          n0;
        fr     = {stop, par, d, 1'b0};
        e.d    = d;
        e.perr = ((^{par, d}) == 1'b0) || !stop;
        rx_exp_q.push_back(e);
        n0 = rx_cnt;
        host_rts();
        host_bits(fr, 10);
        wait_for(1, 1'b0, "rx_ack_low");
        host_data = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (rx_cnt != n0) break;
        end
        check_val("rx_valid_count", rx_cnt - n0, 1);
    endtask

    always @(negedge clk) begin
        if (n_rst && rx_valid) begin
            rx_exp_t e;
            e = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 'x;
            check_val("rx_data", 32'(rx_data), 32'(e.d));
            check_val("rx_parity_err", 32'(rx_parity_err), 32'(e.perr));
            check_val("rx_valid_width", 32'(rxv_prev), 32'(0));
            rx_cnt <= rx_cnt + 1;
        end
        rxv_prev <= rx_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, n_err=%0d", n_err);
        $fatal(1, "timeout");
    end

    initial begin
        int       d;
        int       n0;
        logic [7:0] b;
        host_clk  = 1'b1;
        host_data = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        n_rst     = 1'b1;
        #2 n_rst  = 1'b0;
        #20;
        check_val("rst_n_clk_out", 32'(n_clk_out), 32'(1));
        check_val("rst_n_data_out", 32'(n_data_out), 32'(1));
        check_val("rst_tx_ready", 32'(tx_ready), 32'(1));
        check_val("rst_rx_valid", 32'(rx_valid), 32'(0));
        check_val("rst_rx_data", 32'(rx_data), 32'(0));
        check_val("rst_parity_err", 32'(rx_parity_err), 32'(0));
        check_val("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        n_rst = 1'b1;

        // Transmit 0x1C; a second offer while pending must be ignored.
        send_tx(8'h1C);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        capture_tx(11, 1'b0);
        finish_tx();

        // Host commands: good parity, wrong parity, zero stop bit.
        host_send(8'hED, ~^8'hED, 1'b1);
        b = 8'hFF;
        host_send(b, ^b, 1'b1);
        host_send(8'h3C, ~^8'h3C, 1'b0);

        // Host inhibit during bit 5 aborts; the byte is retried in full.
        repeat (5) @(posedge clk);
        send_tx(8'hAA);
        capture_tx(5, 1'b0);
        wait_for(0, 1'b0, "tx_b5_low");
        check_val("tx_bit5", 32'(n_data_out), 32'(tx_exp_q.pop_front()));
        host_clk = 1'b0;
        repeat (3 * HALF_BIT) @(posedge clk);
        #1;
        check_val("abort_n_clk_out", 32'(n_clk_out), 32'(1));
        check_val("abort_n_data_out", 32'(n_data_out), 32'(1));
        check_val("abort_tx_ready", 32'(tx_ready), 32'(0));
        check_val("abort_busy", 32'(busy), 32'(0));
        tx_exp_q.delete();
        begin
            logic [10:0] fr;
            fr = make_frame(8'hAA);
            for (int i = 0; i < 11; i++) tx_exp_q.push_back(fr[i]);
        end
        host_clk = 1'b1;
        d = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            d++;
            if (!n_clk_out) break;
        end
        check_val("retry_delay_ok", 32'(d >= 3 * HALF_BIT), 32'(1));
        capture_tx(11, 1'b1);
        finish_tx();

        // Pending byte and RTS in the same idle window: receive first, then send.
        host_clk = 1'b0;
        repeat (5) @(posedge clk);
        send_tx(8'h55);
        host_send(8'h12, ~^8'h12, 1'b1);
        capture_tx(11, 1'b0);
        finish_tx();

        // Reset during receive bit 4 releases the lines at once and reports nothing.
        n0 = rx_cnt;
        host_rts();
        host_bits({1'b1, ~^8'h6B, 8'h6B, 1'b0}, 4);
        #2;
        n_rst = 1'b0;
        #1;
        check_val("midrst_n_clk_out", 32'(n_clk_out), 32'(1));
        check_val("midrst_n_data_out", 32'(n_data_out), 32'(1));
        check_val("midrst_busy", 32'(busy), 32'(0));
        check_val("midrst_tx_ready", 32'(tx_ready), 32'(1));
        host_clk  = 1'b1;
        host_data = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_val("midrst_no_rx_valid", rx_cnt - n0, 0);
        check_val("midrst_rx_data", 32'(rx_data), 32'(0));
        check_val("midrst_idle_n_clk", 32'(n_clk_out), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
